// File: rtl/i2c_target.sv
// i2c_target: fixed-address I2C target (slave) with a byte-stream interface.
//
// The raw SCL/SDA pins are synchronized into the clk domain. SCL edges and
// START/STOP conditions are decoded from the synchronized signals. A single
// FSM then walks through the address phase, write bytes (always ACKed) and
// read bytes (continued until the controller NACKs).
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   scl_in     raw bus SCL level (asynchronous)
//   sda_in     raw bus SDA level (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release (open drain)
//   rx_data    last byte written by the controller
//   rx_valid   one-cycle pulse when rx_data updates
//   tx_data    byte to return on a read, latched while tx_req is pulsed
//   tx_req     one-cycle pulse; tx_data is captured in the same cycle
//   busy       high from an address match until STOP or a mismatch
//   nack_seen  one-cycle pulse when the controller NACKs a transmitted byte
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h44
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       nack_seen
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_e;

  state_e     state_q, state_d;
  logic       scl_s1_q, scl_s2_q, scl_h_q;
  logic       sda_s1_q, sda_s2_q, sda_h_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       nack_q, nack_d;

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit, addr_match;
  logic [7:0] shifted;

  // Synchronizers reset to 1 (idle bus level) so reset release never looks
  // like a START on an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise   = scl_s2_q & ~scl_h_q;
  assign scl_fall   = ~scl_s2_q & scl_h_q;
  // SCL must be high on both sides of the SDA edge, so an SDA change that
  // lands in the same sync cycle as an SCL edge is not mistaken for START/STOP.
  assign start_det  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign shifted    = {shift_q[6:0], sda_s2_q};
  assign last_bit   = (cnt_q == 3'd7);
  assign addr_match = (shifted[7:1] == TARGET_ADDR);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
    end
  end

  // Next-state logic. STOP/START take priority over any bit event.
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:     if (scl_rise && last_bit) state_d = addr_match ? ADDR_ACK : WAIT_STOP;
        // The ACK slot spans two SCL falls: the first starts driving ACK,
        // the second (with sda_oe already set) ends the slot.
        ADDR_ACK: if (scl_fall && sda_oe_q) state_d = rw_q ? TX_BYTE : RX_BYTE;
        RX_BYTE:  if (scl_rise && last_bit) state_d = RX_ACK;
        RX_ACK:   if (scl_fall && sda_oe_q) state_d = RX_BYTE;
        TX_BYTE:  if (scl_fall && last_bit) state_d = TX_ACK;
        // TX_ACK is entered with SCL low, so the first event is the ACK
        // sample; a later fall only happens after an ACK.
        TX_ACK: begin
          if (scl_rise && sda_s2_q) state_d = WAIT_STOP;
          else if (scl_fall)        state_d = TX_BYTE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output and datapath logic
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    nack_d     = 1'b0;
    if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = 3'd0;
    end else if (start_det) begin
      // busy is left alone on a repeated START until the address resolves
      sda_oe_d = 1'b0;
      cnt_d    = 3'd0;
      shift_d  = 8'h00;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = shifted;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              rw_d     = sda_s2_q;
              busy_d   = addr_match;
              sda_oe_d = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              tx_req_d = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              cnt_d    = 3'd0;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d = shifted;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit) begin
              rx_data_d  = shifted;
              rx_valid_d = 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) sda_oe_d = ~sda_oe_q;
        end
        TX_BYTE: begin
          // cnt counts falls: 0..6 present the next bit, 7 ends the byte
          if (scl_fall) begin
            cnt_d = cnt_q + 3'd1;
            if (last_bit) begin
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && sda_s2_q) begin
            nack_d = 1'b1;
          end else if (scl_fall) begin
            tx_req_d = 1'b1;
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[7];
            cnt_d    = 3'd0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target acting as a bit-banged I2C
// controller on an open-drain SDA wire.
module tb_i2c_target;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_c;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       nack_seen;

  int n_cmp = 0;
  int n_bad = 0;

  int rxv_cnt  = 0;
  int txr_cnt  = 0;
  int nack_cnt = 0;
  int oe_cnt   = 0;

  logic [7:0] tx_tab [0:3];
  int         tx_base = 0;
  logic [1:0] tx_idx;

  always #5 clk = ~clk;

  assign sda_bus = sda_c & ~sda_oe;
  assign tx_idx  = 2'(txr_cnt - tx_base);
  assign tx_data = tx_tab[tx_idx];

  i2c_target #(.TARGET_ADDR(7'h44)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  // Event monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt  <= rxv_cnt + 1;
    if (tx_req)    txr_cnt  <= txr_cnt + 1;
    if (nack_seen) nack_cnt <= nack_cnt + 1;
    if (sda_oe)    oe_cnt   <= oe_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_c = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_c = 1'b0; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop;
    sda_c = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_c = 1'b1; wait_clk(Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_c = b;    wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    s     = sda_bus; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sda_oe !== 1'b0)     begin n_bad++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    n_cmp++; if (rx_data !== 8'h00)   begin n_bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_cmp++; if (tx_req !== 1'b0)     begin n_bad++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (nack_seen !== 1'b0)  begin n_bad++; $display("FAIL reset_nack_seen got=%b exp=0", nack_seen); end
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    n_cmp++; if (sda_oe !== 1'b0)     begin n_bad++; $display("FAIL post_reset_sda_oe got=%b exp=0", sda_oe); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write;
    logic ack;
    int   rxv0;
    rxv0 = rxv_cnt;
    bus_start;
    write_byte(8'h88, ack);
    n_cmp++; if (ack !== 1'b1)        begin n_bad++; $display("FAIL write_addr_ack got=%b exp=1", ack); end
    n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL write_busy got=%b exp=1", busy); end
    write_byte(8'hFD, ack);
    n_cmp++; if (ack !== 1'b1)        begin n_bad++; $display("FAIL write_data_ack got=%b exp=1", ack); end
    n_cmp++; if (rx_data !== 8'hFD)   begin n_bad++; $display("FAIL write_rx_data got=%h exp=fd", rx_data); end
    n_cmp++; if (rxv_cnt - rxv0 != 1) begin n_bad++; $display("FAIL write_rx_valid_count got=%0d exp=1", rxv_cnt - rxv0); end
    bus_stop;
    wait_clk(4);
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
    n_cmp++; if (sda_oe !== 1'b0)     begin n_bad++; $display("FAIL write_sda_oe_after_stop got=%b exp=0", sda_oe); end
  endtask

  task automatic test_mismatch;
    logic ack;
    int   rxv0, txr0, oe0;
    rxv0 = rxv_cnt; txr0 = txr_cnt; oe0 = oe_cnt;
    bus_start;
    write_byte(8'h8A, ack);
    n_cmp++; if (ack !== 1'b0)        begin n_bad++; $display("FAIL mismatch_ack got=%b exp=0", ack); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mismatch_busy got=%b exp=0", busy); end
    write_byte(8'h55, ack);
    n_cmp++; if (ack !== 1'b0)        begin n_bad++; $display("FAIL mismatch_data_ack got=%b exp=0", ack); end
    n_cmp++; if (oe_cnt != oe0)       begin n_bad++; $display("FAIL mismatch_sda_oe_cycles got=%0d exp=0", oe_cnt - oe0); end
    n_cmp++; if (rxv_cnt != rxv0)     begin n_bad++; $display("FAIL mismatch_rx_valid got=%0d exp=0", rxv_cnt - rxv0); end
    n_cmp++; if (txr_cnt != txr0)     begin n_bad++; $display("FAIL mismatch_tx_req got=%0d exp=0", txr_cnt - txr0); end
    bus_stop;
    wait_clk(4);
  endtask

  task automatic test_read;
    logic       ack;
    logic [7:0] d;
    int         nk0, oe0;
    tx_tab[0] = 8'hA5; tx_tab[1] = 8'h3C; tx_tab[2] = 8'hFF; tx_tab[3] = 8'hFF;
    tx_base = txr_cnt;
    nk0 = nack_cnt;
    bus_start;
    write_byte(8'h89, ack);
    n_cmp++; if (ack !== 1'b1)        begin n_bad++; $display("FAIL read_addr_ack got=%b exp=1", ack); end
    read_byte(1'b0, d);
    n_cmp++; if (d !== 8'hA5)         begin n_bad++; $display("FAIL read_byte0 got=%h exp=a5", d); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'h3C)         begin n_bad++; $display("FAIL read_byte1 got=%h exp=3c", d); end
    n_cmp++; if (txr_cnt - tx_base != 2) begin n_bad++; $display("FAIL read_tx_req_count got=%0d exp=2", txr_cnt - tx_base); end
    n_cmp++; if (nack_cnt - nk0 != 1) begin n_bad++; $display("FAIL read_nack_count got=%0d exp=1", nack_cnt - nk0); end
    n_cmp++; if (sda_oe !== 1'b0)     begin n_bad++; $display("FAIL read_released got=%b exp=0", sda_oe); end
    n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL read_busy_wait_stop got=%b exp=1", busy); end
    // A matching-looking byte while waiting for STOP must be ignored
    oe0 = oe_cnt;
    write_byte(8'h88, ack);
    n_cmp++; if (ack !== 1'b0)        begin n_bad++; $display("FAIL wait_stop_ack got=%b exp=0", ack); end
    n_cmp++; if (oe_cnt != oe0)       begin n_bad++; $display("FAIL wait_stop_sda_oe got=%0d exp=0", oe_cnt - oe0); end
    bus_stop;
    wait_clk(4);
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL read_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_repeated_start;
    logic       ack;
    logic [7:0] d;
    tx_tab[0] = 8'h5A; tx_tab[1] = 8'hFF;
    tx_base = txr_cnt;
    bus_start;
    write_byte(8'h88, ack);
    write_byte(8'hFD, ack);
    n_cmp++; if (ack !== 1'b1)        begin n_bad++; $display("FAIL rs_write_ack got=%b exp=1", ack); end
    bus_start;
    n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL rs_busy_kept got=%b exp=1", busy); end
    write_byte(8'h89, ack);
    n_cmp++; if (ack !== 1'b1)        begin n_bad++; $display("FAIL rs_addr_ack got=%b exp=1", ack); end
    read_byte(1'b1, d);
    n_cmp++; if (d !== 8'h5A)         begin n_bad++; $display("FAIL rs_read_byte got=%h exp=5a", d); end
    n_cmp++; if (rx_data !== 8'hFD)   begin n_bad++; $display("FAIL rs_rx_data got=%h exp=fd", rx_data); end
    bus_stop;
    wait_clk(4);
  endtask

  task automatic test_partial_stop;
    logic ack, s;
    int   rxv0;
    rxv0 = rxv_cnt;
    bus_start;
    write_byte(8'h88, ack);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    bus_stop;
    wait_clk(4);
    n_cmp++; if (rxv_cnt != rxv0)     begin n_bad++; $display("FAIL partial_rx_valid got=%0d exp=0", rxv_cnt - rxv0); end
    n_cmp++; if (sda_oe !== 1'b0)     begin n_bad++; $display("FAIL partial_sda_oe got=%b exp=0", sda_oe); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL partial_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_tx;
    logic ack, s0, s1, s;
    int   oe0;
    tx_tab[0] = 8'h00; tx_tab[1] = 8'h00;
    tx_base = txr_cnt;
    bus_start;
    write_byte(8'h89, ack);
    clk_bit(1'b1, s0);
    clk_bit(1'b1, s1);
    n_cmp++; if ({s0, s1} !== 2'b00)  begin n_bad++; $display("FAIL rmid_bits got=%b exp=00", {s0, s1}); end
    n_cmp++; if (sda_oe !== 1'b1)     begin n_bad++; $display("FAIL rmid_driving got=%b exp=1", sda_oe); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sda_oe !== 1'b0)     begin n_bad++; $display("FAIL rmid_async_release got=%b exp=0", sda_oe); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    wait_clk(2);
    rst_n = 1'b1;
    oe0 = oe_cnt;
    for (int i = 0; i < 7; i++) clk_bit(1'b1, s);
    write_byte(8'h88, ack);
    n_cmp++; if (ack !== 1'b0)        begin n_bad++; $display("FAIL rmid_ignored_ack got=%b exp=0", ack); end
    n_cmp++; if (oe_cnt != oe0)       begin n_bad++; $display("FAIL rmid_sda_oe_cycles got=%0d exp=0", oe_cnt - oe0); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rmid_busy_ignored got=%b exp=0", busy); end
    bus_stop;
    bus_start;
    write_byte(8'h88, ack);
    n_cmp++; if (ack !== 1'b1)        begin n_bad++; $display("FAIL rmid_recover_ack got=%b exp=1", ack); end
    bus_stop;
    wait_clk(4);
  endtask

  initial begin
    rst_n = 1'b1;
    scl   = 1'b1;
    sda_c = 1'b1;
    for (int i = 0; i < 4; i++) tx_tab[i] = 8'hFF;
    test_reset;
    test_write;
    test_mismatch;
    test_read;
    test_repeated_start;
    test_partial_stop;
    test_reset_mid_tx;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
